// File: rtl/fpadd_sched_if.sv
// Requester-side bundle for fpadd_sched: operation requests in, results out.
//   req_valid/req_ready : per-requester operation handshake (one-hot accept)
//   req_A/req_B         : packed operands, requester i at bits [32i+31:32i]
//   rsp_valid/rsp_ready : per-requester result handshake (one-hot valid)
//   rsp_Result          : result for the current owner
// master = requester clients, slave = the scheduler.
interface fpadd_sched_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_A;
  logic [32*NREQ-1:0] req_B;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [31:0]        rsp_Result;

  modport master (
    output req_valid, req_A, req_B, rsp_ready,
    input  req_ready, rsp_valid, rsp_Result
  );

  modport slave (
    input  req_valid, req_A, req_B, rsp_ready,
    output req_ready, rsp_valid, rsp_Result
  );
endinterface

// File: rtl/fpadd_sched.sv
// Shares one five-stage FP adder datapath (mask, align, alu, normal, pack)
// between NREQ requesters. Round-robin arbitration in IDLE, then one stage
// enable per cycle, then the packed result is held for the owner until taken.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   req        : requester bundle (slave side)
//   fp_A, fp_B : registered operands to the datapath
//   stage_en   : one-hot stage-register enable, bit0=mask .. bit4=pack
//   fp_Result  : packed result from the datapath
//   busy       : high whenever an operation is in flight
//   grant_id   : index of the current or last owner
module fpadd_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  fpadd_sched_if.slave    req,
  output logic [31:0]     fp_A,
  output logic [31:0]     fp_B,
  output logic [4:0]      stage_en,
  input  logic [31:0]     fp_Result,
  output logic            busy,
  output logic [IDW-1:0]  grant_id
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MASK  = 3'd1,
    S_ALIGN = 3'd2,
    S_ALU   = 3'd3,
    S_NORM  = 3'd4,
    S_PACK  = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand;
  logic            win_found;
  logic            accept;
  logic [4:0]      stage_en_nx;
  logic [NREQ-1:0] rsp_valid_nx;

  // Round-robin pick: first valid requester scanning upward from rr_ptr.
  always_comb begin
    winner    = rr_ptr;
    cand      = rr_ptr;
    win_found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!win_found && req.req_valid[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  // Next state, combinational grant, and next values of registered outputs.
  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    req.req_ready = '0;
    stage_en_nx   = '0;
    rsp_valid_nx  = '0;

    unique case (state)
      S_IDLE: begin
        if (win_found) begin
          req.req_ready[winner] = 1'b1;
          accept                = 1'b1;
          state_nx              = S_MASK;
        end
      end
      S_MASK:  state_nx = S_ALIGN;
      S_ALIGN: state_nx = S_ALU;
      S_ALU:   state_nx = S_NORM;
      S_NORM:  state_nx = S_PACK;
      S_PACK:  state_nx = S_RESP;
      S_RESP: begin
        if (req.rsp_ready[grant_id]) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // Registered outputs are decoded from the state being entered so they
    // line up with that state's cycle.
    unique case (state_nx)
      S_MASK:  stage_en_nx = 5'b00001;
      S_ALIGN: stage_en_nx = 5'b00010;
      S_ALU:   stage_en_nx = 5'b00100;
      S_NORM:  stage_en_nx = 5'b01000;
      S_PACK:  stage_en_nx = 5'b10000;
      S_RESP:  rsp_valid_nx = NREQ'(1) << grant_id;
      default: stage_en_nx = 5'b00000;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Registered outputs, operand latches, owner and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_en       <= '0;
      busy           <= 1'b0;
      req.rsp_valid  <= '0;
      req.rsp_Result <= '0;
      fp_A           <= '0;
      fp_B           <= '0;
      grant_id       <= '0;
      rr_ptr         <= '0;
    end else begin
      stage_en      <= stage_en_nx;
      busy          <= (state_nx != S_IDLE);
      req.rsp_valid <= rsp_valid_nx;
      if (accept) begin
        fp_A     <= req.req_A[32*32'(winner) +: 32];
        fp_B     <= req.req_B[32*32'(winner) +: 32];
        grant_id <= winner;
        rr_ptr   <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
      end
      if (state == S_PACK) req.rsp_Result <= fp_Result;
    end
  end

endmodule

// File: doc/fpadd_sched.md
Name: fpadd_sched

Overview:
- Controller that shares one five-stage FP adder datapath (mask, align, alu, normal, pack) between NREQ requesters.
- Arbitrates round-robin and latches the winner's operands onto the datapath A/B inputs.
- Sequences the stage-register enables one stage per cycle, captures the packed Result and returns it to the owning requester with a valid/ready handshake.
- Sits between requester clients and the fpbus-connected adder. Only one operation is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of grant_id; must equal clog2(NREQ).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester operation request.
- req_A  input  32*NREQ  operand A, requester i at bits [32i+31:32i].
- req_B  input  32*NREQ  operand B, same packing as req_A.
- req_ready  output  NREQ  one-hot grant/accept.
- rsp_valid  output  NREQ  one-hot: result available to owner.
- rsp_ready  input  NREQ  requester accepts result.
- rsp_Result  output  32  result for the current owner.
- fp_A  output  32  registered operand A to the datapath.
- fp_B  output  32  registered operand B to the datapath.
- stage_en  output  5  one-hot stage-register enable; bit0=mask, bit1=align, bit2=alu, bit3=normal, bit4=pack.
- fp_Result  input  32  packed Result from the datapath.
- busy  output  1  high whenever state != IDLE.
- grant_id  output  IDW  index of the current or last owner.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE, rr_ptr=0, grant_id=0.
  - fp_A=fp_B=0, rsp_Result=0.
  - stage_en=0, rsp_valid=0, req_ready=0, busy=0.
- Reset mid-operation abandons the op; no rsp_valid is issued for it.
- States: IDLE, MASK, ALIGN, ALU, NORM, PACK, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[winner]=1 combinationally; req_ready=0 in all other states.
  - Accept is req_valid[i] & req_ready[i]. On accept:
    - fp_A <= req_A[i], fp_B <= req_B[i], grant_id <= i.
    - rr_ptr <= (i+1) mod NREQ, wrapping NREQ-1 -> 0.
    - next state MASK.
  - No valid request: stay in IDLE; rr_ptr unchanged.
- MASK..PACK:
  - One cycle each, in fixed order MASK -> ALIGN -> ALU -> NORM -> PACK.
  - stage_en is one-hot matching the state (MASK=00001 ... PACK=10000).
  - stage_en=0 in IDLE and RESP.
- PACK: rsp_Result <= fp_Result on the edge leaving PACK; next state RESP.
- RESP:
  - rsp_valid[grant_id]=1; rsp_Result is held stable.
  - On rsp_ready[grant_id]=1: rsp_valid drops on the next edge, state returns to IDLE.
  - Stays in RESP indefinitely under backpressure.
  - rsp_ready of non-owners is ignored.
- Latency: accept at edge 0, stage_en bit k high during cycle k+1, rsp_valid high from cycle 6.
  - Minimum issue interval is 7 cycles (6 plus one IDLE arbitration cycle).
- fp_A/fp_B hold their value from accept until the next accept.
- Requester i may drop req_valid while not granted with no effect.
- req_A/req_B are sampled only at accept.
- Simultaneous requests: exactly one is granted per IDLE cycle; all others wait.
  - Starvation-free: any held request is granted within NREQ operations.
- busy = (state != IDLE).

Test Plan:
- Single op:
  - Stimulus: req_valid=0001, A=0x3F800000, B=0x40000000; datapath model returns A+B.
  - Required: req_ready=0001 in the accept cycle, stage_en walks 00001..10000 over cycles 1-5, rsp_valid=0001 at cycle 6 with rsp_Result=0x40400000.
- Round-robin:
  - Stimulus: all four requesters hold req_valid.
  - Required: grant order 0,1,2,3,0; rr_ptr wraps 3 -> 0.
- Fairness mid-stream:
  - Stimulus: after requester 2 is served, requesters 1 and 3 both request.
  - Required: 3 is granted first, then 1.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles in RESP.
  - Required: rsp_valid and rsp_Result stable, req_ready=0 throughout, busy=1.
  - Then assert rsp_ready for one cycle: IDLE on the next edge.
- Reset mid-op:
  - Stimulus: assert reset during ALU.
  - Required: all outputs zero immediately (async); after deassert, requester 0 wins first (rr_ptr=0); no stale rsp_valid.
- Inf/NaN passthrough:
  - Stimulus: A=0x7F800000, B=0xFF800000.
  - Required: the full 6-cycle sequence still occurs; rsp_Result equals fp_Result sampled at PACK (e.g. 0x7FC00000).
